keypad_event_ctrl: RTL and testbench

Controller that sits downstream of the keypad scanner/encoder and sequences its output into clean key events for the host. It samples the scanner's code and valid strobe, and debounces both press and release with one state machine. Each accepted press is pushed into a small event FIFO, which the host drains through a valid/ready handshake. Overflow is reported with a sticky flag.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_event_fifo.sv | 107 ++++++++++
 rtl/keypad_event_ctrl.sv | 153 +++++++++++++++
 tb/tb_keypad_event_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad event controller:
//   KEY_W                - width of a scanner key code
//   DEF_DEBOUNCE_CYCLES  - default number of identical samples to accept an edge
//   DEF_FIFO_DEPTH       - default depth of the key event FIFO
//   kp_state_e           - debounce state machine states
//   sat_inc8()           - 8-bit saturating increment for the debounce counter
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int KEY_W               = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_FIFO_DEPTH      = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } kp_state_e;

   // Counter sticks at 0xFF instead of wrapping back to zero.
   function automatic logic [7:0] sat_inc8(input logic [7:0] i_val);
      return (i_val == 8'hFF) ? i_val : i_val + 8'd1;
   endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// -----------------------------------------------------------------------------
// keypad_event_fifo
// Synchronous first-word-fall-through FIFO holding accepted key events.
// The head entry is kept in a register so the output never depends
// combinationally on the inputs, and it keeps its last value once empty.
// Ports:
//   i_clock       rising-edge clock
//   i_reset_n     synchronous active-low reset (empties the FIFO)
//   i_push        write request
//   i_push_data   data written on a successful push
//   o_full        all DEPTH entries occupied
//   i_pop_ready   consumer takes the head entry when o_valid is high
//   o_valid       head entry holds valid data
//   o_data        head entry
//   o_count       number of stored entries
//   o_drop        push rejected this cycle (full and no simultaneous pop)
// -----------------------------------------------------------------------------
module keypad_event_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   output logic             o_full,
   input  logic             i_pop_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_drop
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] w_rd_ptr_inc;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_valid;
   logic [WIDTH-1:0] r_head;
   logic             w_full;
   logic             w_pop;
   logic             w_push_ok;

   assign w_full       = (r_count == CNT_W'(DEPTH));
   assign w_pop        = r_valid & i_pop_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push_ok    = i_push & (~w_full | w_pop);
   assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_ok, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage array carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge i_clock) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_head   <= '0;
      end else begin
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         // Head register: next entry from the array on a pop, or the pushed
         // word when it becomes the only entry. Nothing is bypassed in the
         // push cycle itself.
         if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
               r_head <= r_mem[w_rd_ptr_inc];
            end else if (w_push_ok) begin
               r_head <= i_push_data;
            end
         end else if ((r_count == '0) && w_push_ok) begin
            r_head <= i_push_data;
         end
      end
   end

   assign o_full  = w_full;
   assign o_valid = r_valid;
   assign o_data  = r_head;
   assign o_count = r_count;
   assign o_drop  = i_push & w_full & ~w_pop;

endmodule

// File: rtl/keypad_event_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_event_ctrl
// Debounces the keypad scanner output (press and release) and queues each
// accepted press as a key event for the host.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-low reset
//   key_v       scanner valid (a key is decoded)
//   key_data    scanner key code
//   out_valid   event available at the FIFO head
//   out_ready   host takes the head event
//   out_data    key code at the FIFO head
//   fifo_count  number of queued events
//   overflow    sticky: a press was dropped on a full FIFO
//   ovf_clr     clears overflow (a drop on the same edge wins)
//   key_held    a debounced key is down
// -----------------------------------------------------------------------------
module keypad_event_ctrl
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               key_v,
   input  logic [KEY_W-1:0]                   key_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [KEY_W-1:0]                   out_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               overflow,
   input  logic                               ovf_clr,
   output logic                               key_held
);

   localparam logic [7:0] DEB_N = 8'(DEBOUNCE_CYCLES);

   kp_state_e        r_state;
   kp_state_e        w_state_nxt;
   logic [7:0]       r_cnt;
   logic [7:0]       w_cnt_nxt;
   logic [7:0]       w_cnt_inc;
   logic [KEY_W-1:0] r_cand;
   logic [KEY_W-1:0] w_cand_nxt;
   logic             w_push;
   logic             r_held;
   logic             r_ovf;
   logic             w_fifo_full;
   logic             w_fifo_drop;
   logic             w_ovf_set;

   assign w_cnt_inc = sat_inc8(r_cnt);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (key_v) begin
               w_cand_nxt  = key_data;
               w_cnt_nxt   = 8'd1;
               w_state_nxt = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!key_v) begin
               w_cnt_nxt   = 8'd0;
               w_state_nxt = ST_IDLE;
            end else if (key_data != r_cand) begin
               // A different code restarts the run with the new candidate.
               w_cand_nxt = key_data;
               w_cnt_nxt  = 8'd1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == DEB_N) begin
                  w_push      = 1'b1;
                  w_state_nxt = ST_HELD;
               end
            end
         end
         ST_HELD: begin
            // Other codes while held are ghosts and are ignored.
            if (!key_v) begin
               w_cnt_nxt   = 8'd1;
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (key_v) begin
               // Release bounce: the key is still down, no new event.
               w_state_nxt = ST_HELD;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == DEB_N) begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // A drop can only be reported while the FIFO is full.
   assign w_ovf_set = w_fifo_drop & w_fifo_full;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
         r_cand  <= '0;
         r_held  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
         r_held  <= (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE);
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // On a push edge key_data equals r_cand, so the candidate is the event code.
   keypad_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (KEY_W)
   ) u_fifo (
      .i_clock     (clock),
      .i_reset_n   (reset),
      .i_push      (w_push),
      .i_push_data (r_cand),
      .o_full      (w_fifo_full),
      .i_pop_ready (out_ready),
      .o_valid     (out_valid),
      .o_data      (out_data),
      .o_count     (fifo_count),
      .o_drop      (w_fifo_drop)
   );

   assign overflow = r_ovf;
   assign key_held = r_held;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
module tb_keypad_event_ctrl;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          key_v = 1'b0;
   logic [3:0]    key_data = 4'h0;
   logic          out_ready = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          out_valid;
   logic [3:0]    out_data;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          key_held;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   keypad_event_ctrl #(
      .DEBOUNCE_CYCLES (N),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .key_v      (key_v),
      .key_data   (key_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .key_held   (key_held)
   );

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [3:0] ed;
      int         ec;
      logic       eo;
      logic       eh;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic [3:0] d, input logic rdy, input logic clr,
                      input logic ev, input logic [3:0] ed, input int ec, input logic eo,
                      input logic eh, input int rep);
      vec_t t;
      t.v = v; t.d = d; t.rdy = rdy; t.clr = clr;
      t.ev = ev; t.ed = ed; t.ec = ec; t.eo = eo; t.eh = eh;
      for (int i = 0; i < rep; i++) tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic [3:0] ed, input int ec,
                          input logic eo, input logic eh);
      chk({tag, ".out_valid"},  32'(out_valid),  32'(ev));
      chk({tag, ".out_data"},   32'(out_data),   32'(ed));
      chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(ec));
      chk({tag, ".overflow"},   32'(overflow),   32'(eo));
      chk({tag, ".key_held"},   32'(key_held),   32'(eh));
   endtask

   // Drive inputs, take one rising edge, then settle away from the edge.
   task automatic step(input logic v, input logic [3:0] d, input logic rdy, input logic clr);
      key_v = v; key_data = d; out_ready = rdy; ovf_clr = clr;
      @(posedge clock);
      #1;
   endtask

   // Full press (N matching samples) followed by a full release (N zeros).
   task automatic press(input logic [3:0] code);
      for (int i = 0; i < N; i++) step(1'b1, code, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   // ---------------- behavioural reference model ----------------
   // Press: the last N samples are all valid with one code while no key is down.
   // Release: the last N samples are all invalid while a key is down.
   logic       hv[$];
   logic [3:0] hd[$];
   logic [3:0] mq[$];
   logic       m_held;
   logic       m_ovf;
   logic [3:0] m_data;

   task automatic model_step(input logic rst_n, input logic v, input logic [3:0] d,
                             input logic rdy, input logic clr);
      logic pop, push, allv, allz, same;
      logic [3:0] pcode;
      int sz0;
      if (!rst_n) begin
         hv.delete(); hd.delete(); mq.delete();
         m_held = 1'b0; m_ovf = 1'b0; m_data = 4'h0;
         return;
      end
      pop = (mq.size() > 0) && rdy;
      push = 1'b0;
      pcode = 4'h0;
      hv.push_back(v); hd.push_back(d);
      if (hv.size() > N) begin
         void'(hv.pop_front()); void'(hd.pop_front());
      end
      if (hv.size() == N) begin
         allv = 1'b1; allz = 1'b1; same = 1'b1;
         for (int i = 0; i < N; i++) begin
            allv &= hv[i];
            allz &= ~hv[i];
            if (hd[i] != hd[0]) same = 1'b0;
         end
         if (!m_held && allv && same) begin
            push = 1'b1; m_held = 1'b1; pcode = hd[0];
         end else if (m_held && allz) begin
            m_held = 1'b0;
         end
      end
      sz0 = mq.size();
      if (pop) void'(mq.pop_front());
      if (push && (sz0 < DEPTH || pop)) mq.push_back(pcode);
      if (push && !(sz0 < DEPTH || pop)) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (mq.size() > 0) m_data = mq[0];
   endtask

   initial begin
      int run_left;
      logic rv, rst_n;
      logic [3:0] rd, dd;
      logic [1:0] pat [7];

      // ---------- reset state ----------
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_all("reset", 1'b0, 4'h0, 0, 1'b0, 1'b0);
      reset = 1'b1;

      // ---------- table: clean press, press bounce, code change ----------
      add(1, 4'h5, 0, 0,  0, 4'h0, 0, 0, 0, 3);
      add(1, 4'h5, 0, 0,  1, 4'h5, 1, 0, 1, 7);
      add(0, 4'h0, 0, 0,  1, 4'h5, 1, 0, 1, 3);
      add(0, 4'h0, 0, 0,  1, 4'h5, 1, 0, 0, 1);
      add(0, 4'h0, 1, 0,  0, 4'h5, 0, 0, 0, 1);
      add(0, 4'h0, 1, 1,  0, 4'h5, 0, 0, 0, 1);
      add(1, 4'hA, 0, 0,  0, 4'h5, 0, 0, 0, 2);
      add(0, 4'hA, 0, 0,  0, 4'h5, 0, 0, 0, 1);
      add(1, 4'hA, 0, 0,  0, 4'h5, 0, 0, 0, 3);
      add(1, 4'hA, 0, 0,  1, 4'hA, 1, 0, 1, 1);
      add(0, 4'h0, 0, 0,  1, 4'hA, 1, 0, 1, 3);
      add(0, 4'h0, 1, 0,  0, 4'hA, 0, 0, 0, 1);
      add(1, 4'h3, 0, 0,  0, 4'hA, 0, 0, 0, 2);
      add(1, 4'h7, 0, 0,  0, 4'hA, 0, 0, 0, 3);
      add(1, 4'h7, 0, 0,  1, 4'h7, 1, 0, 1, 1);
      add(0, 4'h0, 0, 0,  1, 4'h7, 1, 0, 1, 3);
      add(0, 4'h0, 1, 0,  0, 4'h7, 0, 0, 0, 1);
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         chk_all($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eo, tbl[i].eh);
      end

      // ---------- release bounce ----------
      for (int i = 0; i < N; i++) step(1'b1, 4'h2, 1'b0, 1'b0);
      chk_all("relb.press", 1'b1, 4'h2, 1, 1'b0, 1'b1);
      pat = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
      for (int i = 0; i < 7; i++) begin
         step(pat[i][1], 4'h2, 1'b0, 1'b0);
         chk($sformatf("relb.held[%0d]", i), 32'(key_held), 32'(pat[i][0]));
      end
      chk("relb.count", 32'(fifo_count), 32'd1);
      step(1'b0, 4'h0, 1'b1, 1'b0);
      chk("relb.drained", 32'(fifo_count), 32'd0);

      // ---------- overflow with host stalled ----------
      for (int c = 1; c <= 5; c++) press(4'(c));
      chk_all("ovf.full", 1'b1, 4'h1, 4, 1'b1, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("ovf.drain[%0d].data", c), 32'(out_data), 32'(c));
         chk($sformatf("ovf.drain[%0d].valid", c), 32'(out_valid), 32'd1);
         step(1'b0, 4'h0, 1'b1, 1'b0);
      end
      chk_all("ovf.empty", 1'b0, 4'h4, 0, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      chk("ovf.cleared", 32'(overflow), 32'd0);

      // ---------- push and pop on the same edge while full ----------
      for (int c = 1; c <= 4; c++) press(4'(c));
      chk("pp.count_before", 32'(fifo_count), 32'd4);
      for (int i = 0; i < N - 1; i++) step(1'b1, 4'h6, 1'b0, 1'b0);
      step(1'b1, 4'h6, 1'b1, 1'b0);
      chk_all("pp.after", 1'b1, 4'h2, 4, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) step(1'b0, 4'h0, 1'b0, 1'b0);

      // ---------- reset while debouncing ----------
      step(1'b1, 4'h9, 1'b0, 1'b0);
      step(1'b1, 4'h9, 1'b0, 1'b0);
      reset = 1'b0;
      step(1'b1, 4'h9, 1'b0, 1'b0);
      reset = 1'b1;
      chk_all("rst.mid", 1'b0, 4'h0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 4'h0, 1'b1, 1'b0);
         chk($sformatf("rst.noevent[%0d]", i), 32'(out_valid), 32'd0);
      end

      // ---------- randomized run against the reference model ----------
      reset = 1'b0;
      model_step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0);
      reset = 1'b1;
      run_left = 0;
      rv = 1'b0;
      rd = 4'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (run_left == 0) begin
            rv = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) rd = 4'($urandom_range(0, 15));
            run_left = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(N, N + 6);
         end
         run_left--;
         dd = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : rd;
         rst_n = ($urandom_range(0, 599) != 0);
         reset = rst_n;
         begin
            logic rdy, clr;
            rdy = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            model_step(rst_n, rv, dd, rdy, clr);
            step(rv, dd, rdy, clr);
         end
         reset = 1'b1;
         chk_all($sformatf("rnd[%0d]", cyc), (mq.size() > 0), m_data, mq.size(), m_ovf, m_held);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
